lvds_7to1_rx_align: RTL and testbench
=====================================

# lvds_7to1_rx_align

Receive-side word aligner and bit-unmapper for the single-channel RGB888 LVDS 7:1 video link. It sits between the 1:7 deserializer primitive and the pixel pipeline, all in the recovered pixel-clock domain. It drives the primitive's bit-slip input until the clock-lane word matches the 7:1 clock pattern, then qualifies lock. Once locked, it unmaps the four data lanes back to RGB888 plus HS/VS/DE.

## Interface
Parameters:
- LOCK_CNT, 64: consecutive matching clock words required to declare lock (1..255).
- SLIP_WAIT, 4: idle cycles after each bit-slip pulse before re-sampling (1..15).
- LOSS_CNT, 4: consecutive mismatching clock words in LOCKED that force relock (1..15).

Ports:
- I_pix_clk  in  1  pixel clock (x1); the only clock.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_clk_word  in  7  deserialized clock-lane word; bit 6 is first in time.
- I_rx_0 .. I_rx_3  in  7 each  deserialized data-lane words; bit 6 is first in time.
- O_bitslip  out  1  one-cycle slip request to the deserializer.
- O_lock  out  1  alignment locked.
- O_slip_cnt  out  3  slips since last SEARCH entry, modulo 7.
- O_hs, O_vs, O_de  out  1 each  recovered sync and enable.
- O_data_r, O_data_g, O_data_b  out  8 each  recovered pixel.

## Operation
- Clock pattern CLK_PAT = 7'b1100011. "Match" means I_clk_word == CLK_PAT, sampled every cycle.
- States are SEARCH, WAIT, CHECK and LOCKED. Reset state is SEARCH.
- SEARCH:
  - Match: go to CHECK with match_cnt = 1.
  - Mismatch: pulse O_bitslip for 1 cycle, increment O_slip_cnt (6 wraps to 0), go to WAIT with wait_cnt = SLIP_WAIT.
- WAIT:
  - Ignores the input and decrements wait_cnt.
  - Returns to SEARCH in the cycle after wait_cnt reaches 1.
  - O_bitslip stays low.
- CHECK:
  - Match: increment match_cnt. When match_cnt reaches LOCK_CNT, go to LOCKED.
  - Mismatch: clear match_cnt and go to SEARCH. No slip is issued in that cycle.
- LOCKED:
  - O_lock = 1.
  - Mismatch: increment loss_cnt. Match: clear loss_cnt.
  - When loss_cnt reaches LOSS_CNT, go to SEARCH, clear O_slip_cnt, O_lock = 0.
- Unmap, default VESA:
  - rx0 = {r0,r1,r2,r3,r4,r5,g0}
  - rx1 = {g1,g2,g3,g4,g5,b0,b1}
  - rx2 = {b2,b3,b4,b5,hs,vs,de}
  - rx3 = {r6,r7,g6,g7,b6,b7,rsvd}, where rsvd is ignored.
- Pixel outputs are registered. When the FSM is not LOCKED, O_hs/O_vs/O_de/O_data_* are forced to 0.

## Timing
- Reset values: O_bitslip = 0, O_lock = 0, O_slip_cnt = 0, all pixel and sync outputs 0, counters 0.
- Data latency: I_rx_* sampled in cycle n appears on outputs in cycle n+1 (single register stage).
- O_lock rises in the cycle after the LOCK_CNT-th consecutive matching word is sampled.
  - With LOCK_CNT = 64 and matching input from the first post-reset cycle, O_lock is high in cycle 64 (counting the first sampled cycle as 0).
  - The first valid pixel is the one sampled in that same cycle.
- O_lock falls in the cycle after the LOSS_CNT-th consecutive mismatch. Pixel outputs are 0 from that cycle.
- O_bitslip spacing: minimum SLIP_WAIT+1 cycles between pulses. A full 7-position sweep takes at most 7·(SLIP_WAIT+1) cycles.
- Reset asserted mid-operation: everything returns to reset values asynchronously. Any in-progress slip pulse is truncated.

## Configuration
- RX_JEIDA_EN defined: JEIDA unmap.
  - rx0 = {r2..r7,g2}
  - rx1 = {g3..g7,b2,b3}
  - rx2 = {b4..b7,hs,vs,de}
  - rx3 = {r0,r1,g0,g1,b0,b1,rsvd}
- RX_JEIDA_EN undefined: VESA unmap as in Operation.
- The FSM is identical in both modes.

## Structure
- Package lvds_7to1_rx_pkg holds:
  - CLK_PAT
  - state encoding (SEARCH, WAIT, CHECK, LOCKED)
  - lane width constant 7
- Sub-module lvds_7to1_rx_unmap: purely combinational, four 7-bit words to r/g/b/hs/vs/de. The RX_JEIDA_EN selection lives here.
- The parent holds the FSM, the counters and the output register.

## Test plan
- Aligned from reset: I_clk_word = 1100011 constant, LOCK_CNT = 64. Required: no O_bitslip pulse; O_lock = 1 at cycle 64; O_slip_cnt = 0.
- Misaligned by 3: clock word rotated left by 3, and the bench rotates right by one per O_bitslip. Required: exactly 3 pulses spaced SLIP_WAIT+1 apart; O_slip_cnt = 3; then lock.
- VESA decode: after lock, drive r = 8'hA5, g = 8'h3C, b = 8'hF0, hs = 1, vs = 0, de = 1, mapped onto the lanes. Required: identical values on the outputs one cycle later.
- JEIDA decode: build with RX_JEIDA_EN and repeat the same pixel using the JEIDA lane map. Required: identical output.
- Loss handling while LOCKED:
  - 3 mismatches then a match, LOSS_CNT = 4: O_lock stays 1.
  - 4 consecutive mismatches: O_lock = 0 and outputs = 0 the next cycle; FSM back in SEARCH.
- Reset mid-CHECK: I_rst_n low at match_cnt = 30. Required: all outputs 0 immediately; after release, relock needs a full LOCK_CNT run.

Source files
------------

// File: rtl/lvds_7to1_rx_pkg.sv
// Shared constants and types for the LVDS 7:1 receive aligner: lane width,
// clock-lane pattern, aligner state encoding and the recovered pixel record.
package lvds_7to1_rx_pkg;

    localparam int LANE_W = 7;
    localparam logic [LANE_W-1:0] CLK_PAT = 7'b1100011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_WAIT   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de;
    } rx_pixel_t;

    // Slip position counter wraps after the seventh bit position.
    function automatic logic [2:0] slip_next(input logic [2:0] cnt);
        return (cnt == 3'd6) ? 3'd0 : cnt + 3'd1;
    endfunction

endpackage

// File: rtl/lvds_7to1_rx_unmap.sv
// Combinational lane-to-pixel unmapper for the 4-lane RGB888 7:1 link.
// Default is the VESA bit map; defining RX_JEIDA_EN selects the JEIDA map.
module lvds_7to1_rx_unmap
    import lvds_7to1_rx_pkg::*;
(
    input  logic [LANE_W-1:0] rx_0,
    input  logic [LANE_W-1:0] rx_1,
    input  logic [LANE_W-1:0] rx_2,
    input  logic [LANE_W-1:0] rx_3,
    output rx_pixel_t         pix
);

    // The reserved slot on lane 3 carries no information.
    logic rsvd_unused_s;
    assign rsvd_unused_s = rx_3[0];

    // Bit 6 of every lane word is the first bit in time.
    always_comb begin
        pix = '0;
`ifdef RX_JEIDA_EN
        pix.r  = {rx_0[1], rx_0[2], rx_0[3], rx_0[4], rx_0[5], rx_0[6], rx_3[5], rx_3[6]};
        pix.g  = {rx_1[2], rx_1[3], rx_1[4], rx_1[5], rx_1[6], rx_0[0], rx_3[3], rx_3[4]};
        pix.b  = {rx_2[3], rx_2[4], rx_2[5], rx_2[6], rx_1[0], rx_1[1], rx_3[1], rx_3[2]};
`else
        pix.r  = {rx_3[5], rx_3[6], rx_0[1], rx_0[2], rx_0[3], rx_0[4], rx_0[5], rx_0[6]};
        pix.g  = {rx_3[3], rx_3[4], rx_1[2], rx_1[3], rx_1[4], rx_1[5], rx_1[6], rx_0[0]};
        pix.b  = {rx_3[1], rx_3[2], rx_2[3], rx_2[4], rx_2[5], rx_2[6], rx_1[0], rx_1[1]};
`endif
        pix.hs = rx_2[2];
        pix.vs = rx_2[1];
        pix.de = rx_2[0];
    end

endmodule

// File: rtl/lvds_7to1_rx_align.sv
// LVDS 7:1 receive word aligner: bit-slips the deserializer until the clock
// lane matches CLK_PAT, qualifies lock, then registers the unmapped pixel.
// Lane map selected by RX_JEIDA_EN (see lvds_7to1_rx_unmap).
module lvds_7to1_rx_align
    import lvds_7to1_rx_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int SLIP_WAIT = 4,
    parameter int LOSS_CNT  = 4
) (
    input  logic              I_pix_clk,
    input  logic              I_rst_n,
    input  logic [LANE_W-1:0] I_clk_word,
    input  logic [LANE_W-1:0] I_rx_0,
    input  logic [LANE_W-1:0] I_rx_1,
    input  logic [LANE_W-1:0] I_rx_2,
    input  logic [LANE_W-1:0] I_rx_3,
    output logic              O_bitslip,
    output logic              O_lock,
    output logic [2:0]        O_slip_cnt,
    output logic              O_hs,
    output logic              O_vs,
    output logic              O_de,
    output logic [7:0]        O_data_r,
    output logic [7:0]        O_data_g,
    output logic [7:0]        O_data_b
);

    localparam logic [7:0] LOCK_CNT_C  = 8'(LOCK_CNT);
    localparam logic [3:0] SLIP_WAIT_C = 4'(SLIP_WAIT);
    localparam logic [3:0] LOSS_CNT_C  = 4'(LOSS_CNT);

    rx_state_e  state_r;
    logic [7:0] match_cnt_r;
    logic [3:0] wait_cnt_r;
    logic [3:0] loss_cnt_r;
    logic [2:0] slip_cnt_r;
    logic       bitslip_r;
    logic       lock_r;
    rx_pixel_t  pix_r;

    logic       match_s;
    logic       loss_hit_s;
    logic       pix_valid_s;
    rx_pixel_t  pix_s;

    lvds_7to1_rx_unmap u_unmap (
        .rx_0 (I_rx_0),
        .rx_1 (I_rx_1),
        .rx_2 (I_rx_2),
        .rx_3 (I_rx_3),
        .pix  (pix_s)
    );

    // Pixels pass only while locked and not on the cycle that drops lock.
    always_comb begin
        match_s     = (I_clk_word == CLK_PAT);
        loss_hit_s  = 1'b0;
        pix_valid_s = 1'b0;
        if ((state_r == ST_LOCKED) && !match_s && ((loss_cnt_r + 4'd1) == LOSS_CNT_C)) begin
            loss_hit_s = 1'b1;
        end else begin
            loss_hit_s = 1'b0;
        end
        if ((state_r == ST_LOCKED) && !loss_hit_s) begin
            pix_valid_s = 1'b1;
        end else begin
            pix_valid_s = 1'b0;
        end
    end

    // Alignment FSM with its counters and registered control outputs.
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_r     <= ST_SEARCH;
            match_cnt_r <= 8'd0;
            wait_cnt_r  <= 4'd0;
            loss_cnt_r  <= 4'd0;
            slip_cnt_r  <= 3'd0;
            bitslip_r   <= 1'b0;
            lock_r      <= 1'b0;
        end else begin
            bitslip_r <= 1'b0;
            case (state_r)
                ST_SEARCH: begin
                    if (match_s) begin
                        match_cnt_r <= 8'd1;
                        if (LOCK_CNT_C == 8'd1) begin
                            state_r    <= ST_LOCKED;
                            lock_r     <= 1'b1;
                            loss_cnt_r <= 4'd0;
                        end else begin
                            state_r <= ST_CHECK;
                        end
                    end else begin
                        bitslip_r  <= 1'b1;
                        slip_cnt_r <= slip_next(slip_cnt_r);
                        wait_cnt_r <= SLIP_WAIT_C;
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r <= 4'd1) begin
                        wait_cnt_r <= 4'd0;
                        state_r    <= ST_SEARCH;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (match_s) begin
                        if ((match_cnt_r + 8'd1) == LOCK_CNT_C) begin
                            match_cnt_r <= 8'd0;
                            loss_cnt_r  <= 4'd0;
                            lock_r      <= 1'b1;
                            state_r     <= ST_LOCKED;
                        end else begin
                            match_cnt_r <= match_cnt_r + 8'd1;
                        end
                    end else begin
                        match_cnt_r <= 8'd0;
                        state_r     <= ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        loss_cnt_r <= 4'd0;
                    end else if (loss_hit_s) begin
                        loss_cnt_r <= 4'd0;
                        slip_cnt_r <= 3'd0;
                        lock_r     <= 1'b0;
                        state_r    <= ST_SEARCH;
                    end else begin
                        loss_cnt_r <= loss_cnt_r + 4'd1;
                    end
                end
                default: begin
                    lock_r  <= 1'b0;
                    state_r <= ST_SEARCH;
                end
            endcase
        end
    end

    // Single pixel register stage, blanked when not qualified.
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pix_r <= '0;
        end else if (pix_valid_s) begin
            pix_r <= pix_s;
        end else begin
            pix_r <= '0;
        end
    end

    assign O_bitslip  = bitslip_r;
    assign O_lock     = lock_r;
    assign O_slip_cnt = slip_cnt_r;
    assign O_hs       = pix_r.hs;
    assign O_vs       = pix_r.vs;
    assign O_de       = pix_r.de;
    assign O_data_r   = pix_r.r;
    assign O_data_g   = pix_r.g;
    assign O_data_b   = pix_r.b;

endmodule

// File: tb/tb_lvds_7to1_rx_align.sv
// Self-checking bench for lvds_7to1_rx_align: a rotating-deserializer stimulus,
// a behavioural alignment/pixel model compared every cycle, plus literal pins.
module tb_lvds_7to1_rx_align;

    localparam int LOCK_CNT  = 64;
    localparam int SLIP_WAIT = 4;
    localparam int LOSS_CNT  = 4;
    localparam logic [6:0] PAT = 7'b1100011;
    localparam int M_SEARCH = 0;
    localparam int M_WAIT   = 1;
    localparam int M_CHECK  = 2;
    localparam int M_LOCKED = 3;

    logic       I_pix_clk = 1'b0;
    logic       I_rst_n;
    logic [6:0] I_clk_word;
    logic [6:0] I_rx_0, I_rx_1, I_rx_2, I_rx_3;
    logic       O_bitslip, O_lock, O_hs, O_vs, O_de;
    logic [2:0] O_slip_cnt;
    logic [7:0] O_data_r, O_data_g, O_data_b;

    int checks = 0;
    int errors = 0;
    int p = 0;
    bit glitch = 1'b0;

    logic [7:0] s_r, s_g, s_b;
    logic       s_hs, s_vs, s_de;

    int m_mode, m_run, m_wait, m_loss, m_slips;
    logic       e_bitslip, e_lock, e_hs, e_vs, e_de;
    logic [7:0] e_r, e_g, e_b;

    always #5 I_pix_clk = ~I_pix_clk;

    lvds_7to1_rx_align #(
        .LOCK_CNT  (LOCK_CNT),
        .SLIP_WAIT (SLIP_WAIT),
        .LOSS_CNT  (LOSS_CNT)
    ) dut (
        .I_pix_clk  (I_pix_clk),
        .I_rst_n    (I_rst_n),
        .I_clk_word (I_clk_word),
        .I_rx_0     (I_rx_0),
        .I_rx_1     (I_rx_1),
        .I_rx_2     (I_rx_2),
        .I_rx_3     (I_rx_3),
        .O_bitslip  (O_bitslip),
        .O_lock     (O_lock),
        .O_slip_cnt (O_slip_cnt),
        .O_hs       (O_hs),
        .O_vs       (O_vs),
        .O_de       (O_de),
        .O_data_r   (O_data_r),
        .O_data_g   (O_data_g),
        .O_data_b   (O_data_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] rotl(input logic [6:0] w, input int n);
        logic [6:0] t;
        t = w;
        for (int i = 0; i < n; i++) t = {t[5:0], t[6]};
        return t;
    endfunction

    // Pack a pixel onto the four lanes exactly as the transmitter would.
    task automatic set_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic hs, input logic vs, input logic de, input logic rsvd);
        s_r = r; s_g = g; s_b = b; s_hs = hs; s_vs = vs; s_de = de;
`ifdef RX_JEIDA_EN
        I_rx_0 = {r[2], r[3], r[4], r[5], r[6], r[7], g[2]};
        I_rx_1 = {g[3], g[4], g[5], g[6], g[7], b[2], b[3]};
        I_rx_2 = {b[4], b[5], b[6], b[7], hs, vs, de};
        I_rx_3 = {r[0], r[1], g[0], g[1], b[0], b[1], rsvd};
`else
        I_rx_0 = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
        I_rx_1 = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
        I_rx_2 = {b[2], b[3], b[4], b[5], hs, vs, de};
        I_rx_3 = {r[6], r[7], g[6], g[7], b[6], b[7], rsvd};
`endif
    endtask

    task automatic rand_pixel();
        set_pixel(8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic model_reset();
        m_mode = M_SEARCH; m_run = 0; m_wait = 0; m_loss = 0; m_slips = 0;
        e_bitslip = 1'b0; e_lock = 1'b0;
        e_r = 8'd0; e_g = 8'd0; e_b = 8'd0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0;
    endtask

    // One sampled word: advance the alignment rules and derive expected outputs.
    task automatic model_cycle(input bit mt);
        bit was_locked;
        was_locked = (m_mode == M_LOCKED);
        e_bitslip = 1'b0;
        case (m_mode)
            M_SEARCH: begin
                if (mt) begin
                    m_run = 1;
                    m_loss = 0;
                    m_mode = (m_run == LOCK_CNT) ? M_LOCKED : M_CHECK;
                end else begin
                    e_bitslip = 1'b1;
                    m_slips = (m_slips + 1) % 7;
                    m_wait = SLIP_WAIT;
                    m_mode = M_WAIT;
                end
            end
            M_WAIT: begin
                m_wait--;
                if (m_wait == 0) m_mode = M_SEARCH;
            end
            M_CHECK: begin
                if (mt) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin
                        m_mode = M_LOCKED;
                        m_loss = 0;
                    end
                end else begin
                    m_run = 0;
                    m_mode = M_SEARCH;
                end
            end
            M_LOCKED: begin
                m_loss = mt ? 0 : m_loss + 1;
                if (m_loss == LOSS_CNT) begin
                    m_mode = M_SEARCH;
                    m_slips = 0;
                    m_loss = 0;
                end
            end
            default: m_mode = M_SEARCH;
        endcase
        e_lock = (m_mode == M_LOCKED);
        if (was_locked && m_mode == M_LOCKED) begin
            e_r = s_r; e_g = s_g; e_b = s_b; e_hs = s_hs; e_vs = s_vs; e_de = s_de;
        end else begin
            e_r = 8'd0; e_g = 8'd0; e_b = 8'd0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("bitslip",  32'(O_bitslip),  32'(e_bitslip));
        check("lock",     32'(O_lock),     32'(e_lock));
        check("slip_cnt", 32'(O_slip_cnt), 32'(m_slips));
        check("data_r",   32'(O_data_r),   32'(e_r));
        check("data_g",   32'(O_data_g),   32'(e_g));
        check("data_b",   32'(O_data_b),   32'(e_b));
        check("hs",       32'(O_hs),       32'(e_hs));
        check("vs",       32'(O_vs),       32'(e_vs));
        check("de",       32'(O_de),       32'(e_de));
    endtask

    // Drive a cycle, compare after the edge, then apply any requested slip.
    task automatic step();
        I_clk_word = glitch ? (rotl(PAT, p) ^ 7'b0000100) : rotl(PAT, p);
        @(posedge I_pix_clk);
        #1;
        model_cycle(I_clk_word == PAT);
        compare_all();
        if (O_bitslip === 1'b1) p = (p + 6) % 7;
    endtask

    task automatic do_reset();
        I_rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_outputs", 32'({O_bitslip, O_lock, O_slip_cnt, O_hs, O_vs, O_de,
                                  O_data_r, O_data_g, O_data_b}), 32'd0);
        repeat (2) @(posedge I_pix_clk);
        #1;
        I_rst_n = 1'b1;
    endtask

    task automatic wait_lock(input int bound);
        int k;
        k = 0;
        while (O_lock !== 1'b1 && k < bound) begin
            rand_pixel();
            step();
            k++;
        end
        check("lock_within_bound", 32'(O_lock), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int slips;
        int k;
        int pc[$];
        I_rst_n = 1'b0;
        I_clk_word = PAT;
        rand_pixel();
        do_reset();

        // Aligned from reset: lock appears in cycle 64, no slips.
        slips = 0;
        repeat (LOCK_CNT - 1) begin
            rand_pixel();
            step();
            if (O_bitslip === 1'b1) slips++;
        end
        check("lock_before_64", 32'(O_lock), 32'd0);
        rand_pixel();
        step();
        check("lock_at_64", 32'(O_lock), 32'd1);
        check("aligned_slip_cnt", 32'(O_slip_cnt), 32'd0);
        check("aligned_no_slip", slips, 32'd0);
        check("pre_lock_pixel_blank", 32'({O_data_r, O_data_g, O_data_b, O_de}), 32'd0);

        // Hand-packed lanes for r=A5 g=3C b=F0 hs=1 vs=0 de=1.
        s_r = 8'hA5; s_g = 8'h3C; s_b = 8'hF0; s_hs = 1'b1; s_vs = 1'b0; s_de = 1'b1;
`ifdef RX_JEIDA_EN
        I_rx_0 = 7'b1001011; I_rx_1 = 7'b1110000; I_rx_2 = 7'b1111101; I_rx_3 = 7'b1000000;
`else
        I_rx_0 = 7'b1010010; I_rx_1 = 7'b0111100; I_rx_2 = 7'b0011101; I_rx_3 = 7'b0100110;
`endif
        step();
        check("decode_r", 32'(O_data_r), 32'h0000_00A5);
        check("decode_g", 32'(O_data_g), 32'h0000_003C);
        check("decode_b", 32'(O_data_b), 32'h0000_00F0);
        check("decode_sync", 32'({O_hs, O_vs, O_de}), 32'd5);

        // Random pixels with occasional clock-lane glitches.
        repeat (300) begin
            rand_pixel();
            glitch = ($urandom_range(0, 7) == 0);
            step();
        end
        glitch = 1'b0;
        wait_lock(7 * (SLIP_WAIT + 1) + LOCK_CNT + 40);

        // Three misses then a match keep lock.
        repeat (3) begin
            glitch = 1'b1;
            rand_pixel();
            step();
            check("lock_hold_3miss", 32'(O_lock), 32'd1);
        end
        glitch = 1'b0;
        rand_pixel();
        step();
        check("lock_hold_after_match", 32'(O_lock), 32'd1);

        // Four consecutive misses drop lock and blank the pixel.
        for (int i = 0; i < LOSS_CNT; i++) begin
            glitch = 1'b1;
            set_pixel(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
            step();
            if (i < LOSS_CNT - 1) check("lock_before_loss", 32'(O_lock), 32'd1);
        end
        check("lock_lost", 32'(O_lock), 32'd0);
        check("loss_pixel_blank", 32'({O_data_r, O_data_g, O_data_b, O_hs, O_vs, O_de}), 32'd0);
        glitch = 1'b1;
        step();
        check("search_slip", 32'(O_bitslip), 32'd1);
        check("search_slip_cnt", 32'(O_slip_cnt), 32'd1);
        glitch = 1'b0;
        wait_lock(7 * (SLIP_WAIT + 1) + LOCK_CNT + 20);
        check("wrap_slip_cnt", 32'(O_slip_cnt), 32'd0);

        // Misaligned by 3: three slips five cycles apart, lock in cycle 79.
        p = 3;
        do_reset();
        k = 0;
        while (O_lock !== 1'b1 && k < 400) begin
            rand_pixel();
            step();
            if (O_bitslip === 1'b1) pc.push_back(k);
            k++;
        end
        check("mis3_pulses", pc.size(), 32'd3);
        if (pc.size() == 3) begin
            check("mis3_first", pc[0], 32'd0);
            check("mis3_space1", pc[1] - pc[0], 32'(SLIP_WAIT + 1));
            check("mis3_space2", pc[2] - pc[1], 32'(SLIP_WAIT + 1));
        end
        check("mis3_slip_cnt", 32'(O_slip_cnt), 32'd3);
        check("mis3_lock_cycle", k, 32'd79);

        // Reset in the middle of CHECK, then a full relock run.
        p = 0;
        do_reset();
        repeat (30) begin
            rand_pixel();
            step();
        end
        check("midcheck_no_lock", 32'(O_lock), 32'd0);
        do_reset();
        repeat (LOCK_CNT - 1) begin
            rand_pixel();
            step();
        end
        check("relock_not_early", 32'(O_lock), 32'd0);
        rand_pixel();
        step();
        check("relock_full_run", 32'(O_lock), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
